ac_unit: RTL
============

Name: ac_unit

Overview:
- Registered accumulator datapath for the basic computer: holds AC and E, executes one register-reference or memory-reference AC operation per handshake.
- Generalised to parametrised width.
- Adds multi-bit circulate (CIR/CIL by n positions, one bit per cycle) under a small state machine, and status flags.
- Sits between the control unit, which issues opcodes, and the bus/DR, which supplies operands.

Parameters:
- WIDTH, 16, AC/DR data width (≥2).
- SHW, $clog2(WIDTH+2), localparam; width of the shift-count port.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  control unit presents an operation.
- op_ready  out  1  unit can accept an operation this cycle.
- op  in  4  opcode (encoding in package).
- shamt  in  SHW  rotate count for CIR/CIL; 0 treated as 1; values above WIDTH+1 saturate to WIDTH+1.
- dr_in  in  WIDTH  DR operand, sampled only at accept.
- ac_out  out  WIDTH  AC register.
- e_out  out  1  E register.
- zero  out  1  combinational, ac_out == 0.
- neg  out  1  combinational, ac_out[WIDTH-1].
- done  out  1  one-cycle pulse when an accepted operation has completed.

Behaviour:
- Reset (asynchronous, active-high; takes effect at any time, including mid-rotate):
  - AC=0, E=0, state=IDLE, op_ready=1, done=0, internal count=0.
- States:
  - IDLE: op_ready=1. The operation is accepted on a rising edge with op_valid && op_ready.
  - ROT: op_ready=0. op_valid is ignored; no queuing.
- Single-cycle ops (AC/E update at the accept edge, done=1 in the following cycle, state stays IDLE):
  - AND: AC<=AC&DR; E unchanged.
  - ADD: {E,AC}<=AC+DR, a (WIDTH+1)-bit sum; E=carry out; wraps modulo 2^WIDTH.
  - LDA: AC<=DR.
  - CMA: AC<=~AC.
  - CLA: AC<=0.
  - CLE: E<=0.
  - CME: E<=~E.
  - INC: AC<=AC+1; wraps; E unchanged.
  - Undefined opcode: no state change; done still pulses.
- Rotate ops rotate the WIDTH+1-bit ring {E,AC} by n = effective shamt:
  - CIR step: AC<={E,AC[W-1:1]}, E<=AC[0].
  - CIL step: AC<={AC[W-2:0],E}, E<=AC[W-1].
  - The first step executes at the accept edge.
  - If n=1: behaves as single-cycle.
  - Else: go to ROT with remaining=n-1. Execute one step per edge and decrement. On the edge performing the last step, return to IDLE; done=1 in the next cycle.
  - op_ready is low for exactly n-1 cycles after accept.
  - n=WIDTH+1 restores the original {E,AC}.
- done is registered. It is high the cycle after completion, coincident with op_ready=1, so a new op may be accepted back-to-back while done is high.
- Outputs reflect registers directly; zero/neg follow AC with no extra latency.

Decomposition:
- Package ac_unit_pkg:
  - Opcode localparams: OP_AND=0, OP_ADD=1, OP_LDA=2, OP_CMA=3, OP_CIR=4, OP_CIL=5, OP_CLA=6, OP_CLE=7, OP_CME=8, OP_INC=9.
  - State encoding: IDLE=0, ROT=1.
- One natural sub-module, ac_rot_step: combinational single-bit CIR/CIL of {E,AC}, parametrised by WIDTH, reused at accept and in ROT.
- Single-cycle ALU logic stays inline.

Test Plan:
- ADD wrap: AC=0xFFFF, E=0, ADD DR=0x0001 -> AC=0x0000, E=1, zero=1, done pulses 1 cycle after accept.
- CMA then AND: LDA 0x00FF; CMA -> AC=0xFF00, neg=1; AND DR=0x0F0F -> AC=0x0F00. Three back-to-back accepts, op_ready never low.
- CIL n=4: AC=0x8001, E=1 -> AC=0x001C, E=0. op_ready low 3 cycles; a second op_valid during that window is ignored; done once.
- CIR full ring: AC=0xA5C3, E=1, shamt=17 -> after 16 ROT cycles AC=0xA5C3, E=1. shamt=0 -> single step AC=0xD2E1, E=1.
- Reset mid-rotate: CIR n=10, assert rst asynchronously at cycle 5 -> immediately AC=0, E=0, op_ready=1, done=0. No done after release.
- INC/CLE/CME: AC=0xFFFF, E=1: INC -> AC=0x0000, E=1; CLE -> E=0; CME -> E=1. Undefined opcode 0xF -> no change, done pulses.

Source files
------------

// File: rtl/ac_unit_pkg.sv
// ac_unit_pkg: shared opcode encodings and state type for the accumulator unit.
// Opcodes are 4 bits wide. Any value not listed here is an undefined opcode:
// it changes no state but still produces a done pulse.
package ac_unit_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_CMA = 4'd3;
    localparam logic [3:0] OP_CIR = 4'd4;
    localparam logic [3:0] OP_CIL = 4'd5;
    localparam logic [3:0] OP_CLA = 4'd6;
    localparam logic [3:0] OP_CLE = 4'd7;
    localparam logic [3:0] OP_CME = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ROT  = 1'b1
    } state_t;

endpackage

// File: rtl/ac_rot_step.sv
// ac_rot_step: combinational one-position circulate of the WIDTH+1-bit ring {E,AC}.
// Ports:
//   ac, e           current AC and E
//   left            1 = circulate left (CIL), 0 = circulate right (CIR)
//   ac_next, e_next ring contents after one step
module ac_rot_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] ac,
    input  logic             e,
    input  logic             left,
    output logic [WIDTH-1:0] ac_next,
    output logic             e_next
);

    // Single-bit rotate of {E,AC} in the selected direction
    always_comb begin
        ac_next = ac;
        e_next  = e;
        if (left) begin
            ac_next = {ac[WIDTH-2:0], e};
            e_next  = ac[WIDTH-1];
        end else begin
            ac_next = {e, ac[WIDTH-1:1]};
            e_next  = ac[0];
        end
    end

endmodule

// File: rtl/ac_unit.sv
// ac_unit: registered accumulator datapath (AC, E) for the basic computer.
// Executes one operation per op_valid/op_ready handshake. Multi-position
// circulates run one bit per cycle in the ROT state.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   op_valid/op_ready operation handshake (accept when both high at a rising edge)
//   op, shamt, dr_in  opcode, rotate count, DR operand (sampled at accept)
//   ac_out, e_out     AC and E registers
//   zero, neg         AC status flags (combinational from AC)
//   done              one-cycle pulse after an accepted operation completes
module ac_unit
    import ac_unit_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] dr_in,
    output logic [WIDTH-1:0] ac_out,
    output logic             e_out,
    output logic             zero,
    output logic             neg,
    output logic             done
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0] MAX_N   = SHW'(WIDTH + 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] ac_r;
    logic [WIDTH-1:0] ac_nxt_s;
    logic             e_r;
    logic             e_nxt_s;
    logic [SHW-1:0]   cnt_r;
    logic [SHW-1:0]   cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic [SHW-1:0]   n_s;
    logic             rot_left_s;
    logic [WIDTH-1:0] rot_ac_s;
    logic             rot_e_s;
    logic [WIDTH:0]   sum_s;

    // In ROT the direction latched at accept is used; in IDLE it comes from the opcode
    always_comb begin
        if (state_r == ST_ROT) begin
            rot_left_s = dir_r;
        end else begin
            rot_left_s = (op == OP_CIL);
        end
    end

    ac_rot_step #(.WIDTH(WIDTH)) u_rot_step (
        .ac      (ac_r),
        .e       (e_r),
        .left    (rot_left_s),
        .ac_next (rot_ac_s),
        .e_next  (rot_e_s)
    );

    // Effective rotate count: 0 means 1, anything past the ring length saturates
    always_comb begin
        if (shamt == {SHW{1'b0}}) begin
            n_s = CNT_ONE;
        end else if (shamt > MAX_N) begin
            n_s = MAX_N;
        end else begin
            n_s = shamt;
        end
    end

    assign sum_s = {1'b0, ac_r} + {1'b0, dr_in};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        next_state_s = state_r;
        ac_nxt_s     = ac_r;
        e_nxt_s      = e_r;
        cnt_nxt_s    = cnt_r;
        dir_nxt_s    = dir_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    done_nxt_s = 1'b1;
                    case (op)
                        OP_AND: ac_nxt_s = ac_r & dr_in;
                        OP_ADD: {e_nxt_s, ac_nxt_s} = sum_s;
                        OP_LDA: ac_nxt_s = dr_in;
                        OP_CMA: ac_nxt_s = ~ac_r;
                        OP_CLA: ac_nxt_s = {WIDTH{1'b0}};
                        OP_CLE: e_nxt_s  = 1'b0;
                        OP_CME: e_nxt_s  = ~e_r;
                        OP_INC: ac_nxt_s = ac_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        OP_CIR, OP_CIL: begin
                            // First step happens at the accept edge
                            ac_nxt_s  = rot_ac_s;
                            e_nxt_s   = rot_e_s;
                            dir_nxt_s = (op == OP_CIL);
                            if (n_s != CNT_ONE) begin
                                next_state_s = ST_ROT;
                                cnt_nxt_s    = n_s - CNT_ONE;
                                done_nxt_s   = 1'b0;
                            end else begin
                                cnt_nxt_s = {SHW{1'b0}};
                            end
                        end
                        default: begin
                            // Undefined opcode: no state change, done still pulses
                            ac_nxt_s = ac_r;
                        end
                    endcase
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            ST_ROT: begin
                ac_nxt_s  = rot_ac_s;
                e_nxt_s   = rot_e_s;
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    next_state_s = ST_IDLE;
                    done_nxt_s   = 1'b1;
                end else begin
                    next_state_s = ST_ROT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and done registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_r   <= {WIDTH{1'b0}};
            e_r    <= 1'b0;
            cnt_r  <= {SHW{1'b0}};
            dir_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            ac_r   <= ac_nxt_s;
            e_r    <= e_nxt_s;
            cnt_r  <= cnt_nxt_s;
            dir_r  <= dir_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Output decode from registers
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_ready = 1'b1;
        end else begin
            op_ready = 1'b0;
        end
        ac_out = ac_r;
        e_out  = e_r;
        done   = done_r;
        zero   = (ac_r == {WIDTH{1'b0}});
        neg    = ac_r[WIDTH-1];
    end

endmodule
